matrix_reg_write_decoder: RTL and testbench

//  Bus write side of the 4x4 complex matrix multiplier register map. It decodes

---
 rtl/matrix_reg_write_decoder_pkg.sv | 47 ++++
 rtl/matrix_reg_write_decoder_operand_bank.sv | 40 ++++
 rtl/matrix_reg_write_decoder.sv | 120 ++++++++++++
 tb/tb_matrix_reg_write_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_reg_write_decoder_pkg.sv
// Shared register-map definitions for the 4x4 complex matrix multiplier.
// The read-side output mux imports this same package, so both sides of the
// bus agree on the region bases and on the control FSM encoding.
//   A_BASE / B_BASE  : operand element regions (32 words each)
//   OUT_BASE         : result region, read-only from the bus
//   CTRL_ADDR        : control/status word (launch request, Busy/Done)
package matrix_reg_write_decoder_pkg;

  localparam logic [8:0] A_BASE    = 9'h000;
  localparam logic [8:0] B_BASE    = 9'h080;
  localparam logic [8:0] OUT_BASE  = 9'h100;
  localparam logic [8:0] CTRL_ADDR = 9'h180;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    RG_A,
    RG_B,
    RG_OUT,
    RG_CTRL,
    RG_BAD
  } region_t;

  // Classify a byte address. Misaligned addresses and the unmapped words
  // above the control register fall into RG_BAD.
  function automatic region_t decode_region(input logic [8:0] addr);
    region_t rg;
    rg = RG_BAD;
    if (addr[1:0] == 2'b00) begin
      if (addr == CTRL_ADDR)
        rg = RG_CTRL;
      else if (addr[8:7] == A_BASE[8:7])
        rg = RG_A;
      else if (addr[8:7] == B_BASE[8:7])
        rg = RG_B;
      else if (addr[8:7] == OUT_BASE[8:7])
        rg = RG_OUT;
      else
        rg = RG_BAD;
    end
    return rg;
  endfunction

endpackage

// File: rtl/matrix_reg_write_decoder_operand_bank.sv
// matrix_operand_bank: 32 x Width register file holding one 4x4 complex
// operand matrix. Word index i: row = i[4:3], col = i[2:1], imag = i[0],
// so the packed element slot (4*row + col) is simply i[4:1].
// Ports:
//   clk, reset       clock and synchronous active-high clear
//   we, idx, wdata   single write port
//   real_out         16 real parts, element k at [k*Width +: Width]
//   imag_out         16 imaginary parts, same packing
// All elements are visible in parallel, so storage is flip-flops rather
// than a RAM with a registered read.
module matrix_operand_bank #(
  parameter int Width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [4:0]            idx,
  input  logic [Width-1:0]      wdata,
  output logic [16*Width-1:0]   real_out,
  output logic [16*Width-1:0]   imag_out
);

  logic [Width-1:0] mem_reg [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 32; k++)
        mem_reg[k] <= '0;
    end else if (we) begin
      mem_reg[idx] <= wdata;
    end
  end

  // Even words are real parts, odd words the matching imaginary parts.
  for (genvar gi = 0; gi < 16; gi++) begin : g_pack
    assign real_out[gi*Width +: Width] = mem_reg[2*gi];
    assign imag_out[gi*Width +: Width] = mem_reg[2*gi+1];
  end

endmodule

// File: rtl/matrix_reg_write_decoder.sv
// matrix_reg_write_decoder: bus write side of the matrix multiplier
// register map. Decodes writes into the A/B operand banks and the control
// word, launches the core and tracks Busy / DoneSticky.
// Ports:
//   Clk, Reset          clock, synchronous active-high reset
//   Write, Address,     one write transfer per cycle Write is high
//   WriteData
//   CoreDone            completion pulse from the core
//   AReal..BImag        packed operand elements to the core / read mux
//   StartReg            {0.., DoneSticky, Busy} for readback at 0x180
//   StartPulse          one-cycle launch strobe
//   WriteAck, WriteErr  one-cycle response, one cycle after the transfer
module matrix_reg_write_decoder
  import matrix_reg_write_decoder_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Write,
  input  logic [8:0]            Address,
  input  logic [31:0]           WriteData,
  input  logic                  CoreDone,
  output logic [16*Width-1:0]   AReal,
  output logic [16*Width-1:0]   AImag,
  output logic [16*Width-1:0]   BReal,
  output logic [16*Width-1:0]   BImag,
  output logic [Width-1:0]      StartReg,
  output logic                  StartPulse,
  output logic                  WriteAck,
  output logic                  WriteErr
);

  state_t  state_reg, state_next;
  logic    done_reg, done_next;
  logic    pulse_reg, ack_reg, err_reg;
  region_t region;
  logic    accept, reject, launch;
  logic    we_a, we_b;

  // Only the low Width bits of a write are stored.
  logic unused_wdata;
  assign unused_wdata = ^WriteData[31:Width];

  assign region = decode_region(Address);

  // While BUSY every writable region is frozen, so all writes are rejected.
  always_comb begin
    accept = 1'b0;
    if (Write && state_reg == ST_IDLE)
      accept = (region == RG_A) || (region == RG_B) || (region == RG_CTRL);
  end

  assign reject = Write && !accept;
  assign launch = accept && (region == RG_CTRL) && WriteData[0];
  assign we_a   = accept && (region == RG_A);
  assign we_b   = accept && (region == RG_B);

  always_comb begin
    state_next = state_reg;
    done_next  = done_reg;
    case (state_reg)
      ST_IDLE: begin
        if (launch) begin
          state_next = ST_BUSY;
          done_next  = 1'b0;
        end
      end
      ST_BUSY: begin
        if (CoreDone) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      pulse_reg <= 1'b0;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      pulse_reg <= launch;
      ack_reg   <= accept;
      err_reg   <= reject;
    end
  end

  assign StartReg   = {{(Width-2){1'b0}}, done_reg, state_reg == ST_BUSY};
  assign StartPulse = pulse_reg;
  assign WriteAck   = ack_reg;
  assign WriteErr   = err_reg;

  matrix_operand_bank #(.Width(Width)) u_bank_a (
    .clk      (Clk),
    .reset    (Reset),
    .we       (we_a),
    .idx      (Address[6:2]),
    .wdata    (WriteData[Width-1:0]),
    .real_out (AReal),
    .imag_out (AImag)
  );

  matrix_operand_bank #(.Width(Width)) u_bank_b (
    .clk      (Clk),
    .reset    (Reset),
    .we       (we_b),
    .idx      (Address[6:2]),
    .wdata    (WriteData[Width-1:0]),
    .real_out (BReal),
    .imag_out (BImag)
  );

endmodule

// File: tb/tb_matrix_reg_write_decoder.sv
module tb_matrix_reg_write_decoder;

  localparam int W = 8;

  logic            Clk;
  logic            Reset;
  logic            Write;
  logic [8:0]      Address;
  logic [31:0]     WriteData;
  logic            CoreDone;
  logic [16*W-1:0] AReal, AImag, BReal, BImag;
  logic [W-1:0]    StartReg;
  logic            StartPulse, WriteAck, WriteErr;

  int n_vec = 0;
  int n_err = 0;

  matrix_reg_write_decoder #(.Width(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Write      (Write),
    .Address    (Address),
    .WriteData  (WriteData),
    .CoreDone   (CoreDone),
    .AReal      (AReal),
    .AImag      (AImag),
    .BReal      (BReal),
    .BImag      (BImag),
    .StartReg   (StartReg),
    .StartPulse (StartPulse),
    .WriteAck   (WriteAck),
    .WriteErr   (WriteErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // esel: 0 none, 1 A real, 2 A imag, 3 B real, 4 B imag; eslot = 4*(r-1)+(c-1)
  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        cd;
    logic        ack;
    logic        err;
    logic        pulse;
    logic [7:0]  sreg;
    int          esel;
    int          eslot;
    logic [7:0]  eval;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_elem(input int sel, input int slot);
    case (sel)
      1: return AReal[slot*W +: W];
      2: return AImag[slot*W +: W];
      3: return BReal[slot*W +: W];
      default: return BImag[slot*W +: W];
    endcase
  endfunction

  // Present one transfer, let it be sampled, and settle just after the edge.
  task automatic drive(input logic wr, input logic [8:0] a, input logic [31:0] d, input logic cd);
    Write     = wr;
    Address   = a;
    WriteData = d;
    CoreDone  = cd;
    @(posedge Clk);
    #1;
    Write    = 1'b0;
    CoreDone = 1'b0;
  endtask

  task automatic check_strobes(input string tag, input logic ack, input logic err,
                               input logic pulse, input logic [7:0] sreg);
    check({tag, ".ack"},   128'(WriteAck),   128'(ack));
    check({tag, ".err"},   128'(WriteErr),   128'(err));
    check({tag, ".pulse"}, 128'(StartPulse), 128'(pulse));
    check({tag, ".sreg"},  128'(StartReg),   128'(sreg));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".areal"}, AReal, '0);
    check({tag, ".aimag"}, AImag, '0);
    check({tag, ".breal"}, BReal, '0);
    check({tag, ".bimag"}, BImag, '0);
    check_strobes(tag, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] d8;
    int         slot;
    int         sel;

    vecs[0]  = '{1'b1, 9'h000, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 0,  8'h05};
    vecs[1]  = '{1'b1, 9'h004, 32'h0000_00FB, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2, 0,  8'hFB};
    vecs[2]  = '{1'b0, 9'h000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1,  8'h00};
    vecs[3]  = '{1'b1, 9'h088, 32'h0000_007F, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3, 1,  8'h7F};
    vecs[4]  = '{1'b1, 9'h0FC, 32'h1234_5680, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4, 15, 8'h80};
    vecs[5]  = '{1'b1, 9'h102, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3, 1,  8'h7F};
    vecs[6]  = '{1'b1, 9'h104, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4, 15, 8'h80};
    vecs[7]  = '{1'b1, 9'h180, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0,  8'h00};
    vecs[8]  = '{1'b1, 9'h180, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 0, 0,  8'h00};
    vecs[9]  = '{1'b0, 9'h000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 0, 0,  8'h00};
    vecs[10] = '{1'b1, 9'h000, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1, 0,  8'h05};
    vecs[11] = '{1'b1, 9'h180, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 0, 0,  8'h00};
    vecs[12] = '{1'b1, 9'h000, 32'h0000_0022, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 1, 0,  8'h05};
    vecs[13] = '{1'b1, 9'h000, 32'h0000_0022, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 1, 0,  8'h22};
    vecs[14] = '{1'b0, 9'h000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 0, 0,  8'h00};
    vecs[15] = '{1'b1, 9'h181, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 0, 0,  8'h00};
    vecs[16] = '{1'b1, 9'h1FC, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 0, 0,  8'h00};
    vecs[17] = '{1'b1, 9'h180, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 0, 0,  8'h00};

    Reset     = 1'b1;
    Write     = 1'b0;
    Address   = '0;
    WriteData = '0;
    CoreDone  = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    Reset = 1'b0;

    for (int v = 0; v < 18; v++) begin
      drive(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].cd);
      $display("vec %0d: wr=%0b addr=%03h data=%08h cd=%0b -> ack=%0b err=%0b pulse=%0b sreg=%02h",
               v, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].cd,
               WriteAck, WriteErr, StartPulse, StartReg);
      check_strobes($sformatf("vec%0d", v), vecs[v].ack, vecs[v].err, vecs[v].pulse, vecs[v].sreg);
      if (vecs[v].esel != 0)
        check($sformatf("vec%0d.elem", v), 128'(get_elem(vecs[v].esel, vecs[v].eslot)),
              128'(vecs[v].eval));
    end

    // Pulse after launch lasts exactly one cycle.
    drive(1'b0, 9'h000, 32'h0, 1'b0);
    $display("busy idle: pulse=%0b sreg=%02h", StartPulse, StartReg);
    check_strobes("busy_idle", 1'b0, 1'b0, 1'b0, 8'h01);

    // Reset while BUSY abandons the computation; a late CoreDone is ignored.
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    $display("reset in busy: sreg=%02h", StartReg);
    check_all_zero("busy_reset");
    drive(1'b0, 9'h000, 32'h0, 1'b1);
    $display("late coredone: sreg=%02h pulse=%0b", StartReg, StartPulse);
    check_strobes("late_done", 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 9'h000, 32'h0, 1'b0);
    check_strobes("late_done2", 1'b0, 1'b0, 1'b0, 8'h00);

    // 64 back-to-back writes across A and B with distinct low bytes.
    for (int i = 0; i < 64; i++) begin
      d8 = 8'((i * 7 + 3) & 8'hFF);
      drive(1'b1, 9'(i * 4), {24'hA5A5_00, d8}, 1'b0);
      $display("burst %0d: addr=%03h data=%02h ack=%0b err=%0b", i, 9'(i * 4), d8, WriteAck, WriteErr);
      check($sformatf("burst%0d.ack", i), 128'(WriteAck), 128'(1'b1));
      check($sformatf("burst%0d.err", i), 128'(WriteErr), 128'(1'b0));
    end
    drive(1'b0, 9'h000, 32'h0, 1'b0);
    check("burst_end.ack", 128'(WriteAck), 128'(1'b0));
    for (int i = 0; i < 64; i++) begin
      d8   = 8'((i * 7 + 3) & 8'hFF);
      slot = (i >> 1) & 15;
      sel  = ((i >> 5) & 1) * 2 + (i & 1) + 1;
      check($sformatf("burst_elem%0d", i), 128'(get_elem(sel, slot)), 128'(d8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
